// File: rtl/clock_divider_multi_pkg.sv
// rtl/clock_divider_multi_pkg.sv - shared constants and helpers for the multi-channel clock divider
package clock_divider_pkg;

   // Divisors below this value stop the channel instead of producing a waveform
   localparam int MIN_RUN_DIV = 2;

   // Channel-select width, never narrower than one bit
   function automatic int ch_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/clock_divider_multi_if.sv
// rtl/clock_divider_multi_if.sv - divisor configuration valid/ready port
interface clock_divider_multi_if #(
   parameter int NUM_CH = 4,
   parameter int DIV_W  = 8
);
   import clock_divider_pkg::*;

   localparam int CH_W = ch_w(NUM_CH);

   logic             valid;
   logic             ready;
   logic [CH_W-1:0]  ch;
   logic [DIV_W-1:0] div;

   modport master (output valid, ch, div, input ready);
   modport slave  (input valid, ch, div, output ready);
endinterface

// File: rtl/clock_divider_multi_ch.sv
// rtl/clock_divider_multi_ch.sv - one divider channel with boundary-aligned divisor and enable updates
module clock_divider_ch #(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             en,
   input  logic             wr,
   input  logic [DIV_W-1:0] wr_div,
   output logic             pending,
   output logic             clk_out,
   output logic             tick
);
   import clock_divider_pkg::*;

   typedef struct packed {
      logic [DIV_W-1:0] cnt;
      logic [DIV_W-1:0] div_active;
      logic [DIV_W-1:0] div_shadow;
      logic             pending;
      logic             running;
   } ch_state_t;

   ch_state_t        st;
   ch_state_t        st_nxt;
   logic             boundary;
   logic [DIV_W:0]   half;
   logic             clk_nxt;
   logic             tick_nxt;

   // Next state: apply a pending divisor and re-sample en only at the period boundary
   always_comb begin
      st_nxt   = st;
      boundary = !st.running || (st.cnt == st.div_active - 1'b1);
      if (boundary) begin
         if (st.pending) begin
            st_nxt.div_active = st.div_shadow;
            st_nxt.pending    = 1'b0;
         end
         st_nxt.running = en && (st_nxt.div_active >= DIV_W'(MIN_RUN_DIV));
         st_nxt.cnt     = '0;
      end else begin
         st_nxt.cnt = st.cnt + 1'b1;
      end
      // A write landing on a boundary is only seen at the following boundary
      if (wr) begin
         st_nxt.div_shadow = wr_div;
         st_nxt.pending    = 1'b1;
      end
      half     = ({1'b0, st_nxt.div_active} + 1'b1) >> 1;
      clk_nxt  = st_nxt.running && ({1'b0, st_nxt.cnt} < half);
      tick_nxt = st_nxt.running && (st_nxt.cnt == '0);
   end

   // State and registered outputs; reset drops outputs immediately
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         st <= '{cnt: '0, div_active: DIV_W'(DEFAULT_DIV), div_shadow: DIV_W'(DEFAULT_DIV),
                 pending: 1'b0, running: 1'b0};
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else begin
         st      <= st_nxt;
         clk_out <= clk_nxt;
         tick    <= tick_nxt;
      end
   end

   assign pending = st.pending;

endmodule

// File: rtl/clock_divider_multi.sv
// rtl/clock_divider_multi.sv - NUM_CH programmable clock dividers behind one config port
module clock_divider_multi #(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic                clk_in,
   input  logic                rst_n,
   input  logic [NUM_CH-1:0]   en,
   clock_divider_multi_if.slave cfg,
   output logic [NUM_CH-1:0]   clk_out,
   output logic [NUM_CH-1:0]   tick
);
   import clock_divider_pkg::*;

   localparam int CH_W    = ch_w(NUM_CH);
   localparam int CH_SPAN = 2 ** CH_W;

   logic [NUM_CH-1:0]  pending;
   logic [NUM_CH-1:0]  wr;
   logic [CH_SPAN-1:0] pend_pad;
   logic               ready;

   // Unused channel codes read as never-pending, so out-of-range writes are always accepted
   always_comb begin
      pend_pad               = '0;
      pend_pad[NUM_CH-1:0]   = pending;
   end

   assign ready     = !pend_pad[cfg.ch];
   assign cfg.ready = ready;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign wr[i] = cfg.valid && ready && (cfg.ch == CH_W'(i));

      clock_divider_ch #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk_in  (clk_in),
         .rst_n   (rst_n),
         .en      (en[i]),
         .wr      (wr[i]),
         .wr_div  (cfg.div),
         .pending (pending[i]),
         .clk_out (clk_out[i]),
         .tick    (tick[i])
      );
   end

endmodule

// File: tb/tb_clock_divider_multi.sv
// tb/tb_clock_divider_multi.sv - directed bench for clock_divider_multi
module tb_clock_divider_multi;

   logic       clk_in = 1'b0;
   logic       rst_n;
   logic [3:0] en;
   logic [3:0] clk_out;
   logic [3:0] tick;
   logic [2:0] en_b;
   logic [2:0] clk_out_b;
   logic [2:0] tick_b;
   int         vectors = 0;
   int         miscompares = 0;

   clock_divider_multi_if #(.NUM_CH(4), .DIV_W(8)) cfg_a ();
   clock_divider_multi_if #(.NUM_CH(3), .DIV_W(8)) cfg_b ();

   clock_divider_multi #(.NUM_CH(4), .DIV_W(8), .DEFAULT_DIV(4)) dut (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .en      (en),
      .cfg     (cfg_a),
      .clk_out (clk_out),
      .tick    (tick)
   );

   clock_divider_multi #(.NUM_CH(3), .DIV_W(8), .DEFAULT_DIV(4)) dut_b (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .en      (en_b),
      .cfg     (cfg_b),
      .clk_out (clk_out_b),
      .tick    (tick_b)
   );

   always #5 clk_in = ~clk_in;

   task automatic cyc();
      @(posedge clk_in);
      @(negedge clk_in);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // cs/ts list the expected per-cycle values left to right (MSB = first edge)
   task automatic expect_seq(input int ch, input int n, input logic [15:0] cs,
                             input logic [15:0] ts, input string tag);
      for (int k = 0; k < n; k++) begin
         cyc();
         chk($sformatf("%s_clk%0d", tag, k), clk_out[ch], cs[n-1-k]);
         chk($sformatf("%s_tick%0d", tag, k), tick[ch], ts[n-1-k]);
      end
   endtask

   task automatic expect_b(input int n, input logic [15:0] cs, input logic [15:0] ts,
                           input string tag);
      for (int k = 0; k < n; k++) begin
         cyc();
         chk($sformatf("%s_clk%0d", tag, k), clk_out_b, {3{cs[n-1-k]}});
         chk($sformatf("%s_tick%0d", tag, k), tick_b, {3{ts[n-1-k]}});
      end
   endtask

   initial begin
      rst_n = 1'b0;
      en = 4'b0000;
      en_b = 3'b000;
      cfg_a.valid = 1'b0; cfg_a.ch = '0; cfg_a.div = '0;
      cfg_b.valid = 1'b0; cfg_b.ch = '0; cfg_b.div = '0;
      repeat (2) @(negedge clk_in);
      chk("reset_clk_out", clk_out, 4'b0000);
      chk("reset_tick", tick, 4'b0000);
      chk("reset_ready", cfg_a.ready, 1'b1);

      // Default divisor 4 from the first edge after reset release
      en = 4'b0001;
      rst_n = 1'b1;
      expect_seq(0, 8, 16'b11001100, 16'b10001000, "ch0_div4");
      chk("idle_others", clk_out[3:1], 3'b000);

      // Divisor 5 written mid-period waits for the boundary; ch1 stays writable
      cyc();
      cyc();
      cfg_a.valid = 1'b1; cfg_a.ch = 2'd0; cfg_a.div = 8'd5;
      #1 chk("ready_ch0_free", cfg_a.ready, 1'b1);
      cyc();
      chk("ch0_old_period", clk_out[0], 1'b0);
      cfg_a.ch = 2'd0;
      #1 chk("ready_ch0_busy", cfg_a.ready, 1'b0);
      cfg_a.ch = 2'd1; cfg_a.div = 8'd3;
      #1 chk("ready_ch1_free", cfg_a.ready, 1'b1);
      cyc();
      cfg_a.valid = 1'b0; cfg_a.ch = 2'd0;
      #1 chk("ready_ch0_still_busy", cfg_a.ready, 1'b0);
      expect_seq(0, 10, 16'b1110011100, 16'b1000010000, "ch0_div5");
      chk("ready_ch0_after_apply", cfg_a.ready, 1'b1);
      chk("ch1_disabled", clk_out[1], 1'b0);

      // Stop code on ch2, written on the same edge the channel starts
      en = 4'b0101;
      cfg_a.valid = 1'b1; cfg_a.ch = 2'd2; cfg_a.div = 8'd1;
      cyc();
      cfg_a.valid = 1'b0;
      chk("ch2_start_clk", clk_out[2], 1'b1);
      chk("ch2_start_tick", tick[2], 1'b1);
      expect_seq(2, 7, 16'b1000000, 16'b0000000, "ch2_stop");

      // Divisor 6 on the idle ch2: accepted on one edge, running after the next
      cfg_a.valid = 1'b1; cfg_a.ch = 2'd2; cfg_a.div = 8'd6;
      cyc();
      cfg_a.valid = 1'b0;
      chk("ch2_accept_edge", clk_out[2], 1'b0);
      expect_seq(2, 7, 16'b1110001, 16'b1000001, "ch2_div6");

      // Back to divisor 4 on ch0, then drop en at cnt = 1
      cfg_a.valid = 1'b1; cfg_a.ch = 2'd0; cfg_a.div = 8'd4;
      cyc();
      cfg_a.valid = 1'b0;
      chk("ch0_div5_cnt1", clk_out[0], 1'b1);
      #1 chk("ready_ch0_pending4", cfg_a.ready, 1'b0);
      expect_seq(0, 5, 16'b10011, 16'b00010, "ch0_to_div4");
      en = 4'b0100;
      expect_seq(0, 6, 16'b000000, 16'b000000, "ch0_en_off");
      en = 4'b0101;
      expect_seq(0, 4, 16'b1100, 16'b1000, "ch0_en_on");

      // Out-of-range channel on a three-channel instance is accepted and dropped
      en_b = 3'b111;
      cfg_b.valid = 1'b1; cfg_b.ch = 2'd3; cfg_b.div = 8'd7;
      #1 chk("oor_ready", cfg_b.ready, 1'b1);
      cyc();
      cfg_b.valid = 1'b0;
      chk("oor_ready_after", cfg_b.ready, 1'b1);
      chk("oor_start_clk", clk_out_b, 3'b111);
      chk("oor_start_tick", tick_b, 3'b111);
      expect_b(7, 16'b1001100, 16'b0001000, "oor_pattern");
      cfg_b.ch = 2'd0;
      #1 chk("oor_ch0_ready", cfg_b.ready, 1'b1);

      // Divisor 5 on ch0, then asynchronous reset in the high phase
      cfg_a.valid = 1'b1; cfg_a.ch = 2'd0; cfg_a.div = 8'd5;
      cyc();
      cfg_a.valid = 1'b0;
      repeat (6) cyc();
      chk("pre_reset_ch0", clk_out[0], 1'b1);
      chk("pre_reset_ch2", clk_out[2], 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_clk_out", clk_out, 4'b0000);
      chk("async_reset_tick", tick, 4'b0000);
      chk("async_reset_clk_out_b", clk_out_b, 3'b000);
      repeat (2) @(negedge clk_in);
      rst_n = 1'b1;
      expect_seq(0, 8, 16'b11001100, 16'b10001000, "ch0_post_reset");
      expect_seq(2, 4, 16'b1100, 16'b1000, "ch2_post_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
